// File: rtl/history_regfile_pkg.sv
// Shared types and default sizes for the history register file.
// Imported by history_regfile and history_delay_line.
package history_regfile_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/history_delay_line.sv
// Two-stage history of the read data, with a validity shift register.
// Ports: clk, rst_n (async low), d in; q1/q2 delayed by 1/2 cycles, vld[1:0].
module history_delay_line
   import history_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q1,
   output logic [DATA_W-1:0] q2,
   output logic [1:0]        vld
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1  <= '0;
         q2  <= '0;
         vld <= 2'b00;
      end else begin
         q1  <= d;
         q2  <= q1;
         vld <= {vld[0], 1'b1};
      end
   end

endmodule

// File: rtl/history_regfile.sv
// Indexed register file: valid/ready write port, combinational read,
// 1- and 2-cycle read history, self-clearing sweep after reset or clr_req.
// Ports: clk, rst_n, clr_req, wr_valid/wr_ready/wr_index/wr_data,
// rd_index/rd_data, past1_data, past2_data, past_valid, busy, wr_count.
// HISTORY_REGFILE_ASSERT_EN adds concurrent properties on the history.
module history_regfile
   import history_regfile_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int CNT_W  = DEF_CNT_W,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_index,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] past1_data,
   output logic [DATA_W-1:0] past2_data,
   output logic [1:0]        past_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count
);

   state_t            state;
   logic [IDX_W-1:0]  clr_ptr;
   logic [CNT_W-1:0]  cnt_q;
   logic              wr_acc;
   logic [DATA_W-1:0] regs [DEPTH];

   assign busy     = (state == ST_CLEAR);
   assign wr_ready = (state == ST_IDLE) && !clr_req;
   assign wr_acc   = wr_valid && wr_ready;
   assign wr_count = cnt_q;
   assign rd_data  = regs[rd_index];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               if (clr_ptr == IDX_W'(DEPTH - 1)) begin
                  state   <= ST_IDLE;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + 1'b1;
               end
            end
            ST_IDLE: begin
               if (clr_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= '0;
               end
            end
            default: state <= ST_CLEAR;
         endcase
         if (wr_acc)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // Storage has no reset; the sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         regs[clr_ptr] <= '0;
      else if (wr_acc)
         regs[wr_index] <= wr_data;
   end

   history_delay_line #(
      .DATA_W (DATA_W)
   ) u_hist (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rd_data),
      .q1    (past1_data),
      .q2    (past2_data),
      .vld   (past_valid)
   );

`ifdef HISTORY_REGFILE_ASSERT_EN
   a_past1: assert property (@(posedge clk)
      disable iff (!rst_n || !past_valid[0])
      past1_data == $past(rd_data));

   a_past2: assert property (@(posedge clk)
      disable iff (!rst_n || !past_valid[1])
      past2_data == $past(rd_data, 2));

   a_noacc: assert property (@(posedge clk)
      busy |-> !wr_ready);

   m_hold: assume property (@(posedge clk)
      wr_valid && !wr_ready |=> wr_valid);

   c_wrap: cover property (@(posedge clk)
      disable iff (!rst_n)
      wr_acc ##1 (wr_count == '0));
`else
`endif

endmodule

// File: tb/tb_history_regfile.sv
// Directed bench for history_regfile with a read-history scoreboard.
// Inputs change on negedge; outputs are checked between edges.
module tb_history_regfile;
   import history_regfile_pkg::*;

   localparam int DW = 8;
   localparam int DP = 8;
   localparam int IW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr_req;
   logic          wr_valid;
   logic          wr_ready;
   logic [IW-1:0] wr_index;
   logic [DW-1:0] wr_data;
   logic [IW-1:0] rd_index;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] past1_data;
   logic [DW-1:0] past2_data;
   logic [1:0]    past_valid;
   logic          busy;
   logic [CW-1:0] wr_count;

   history_regfile #(
      .DATA_W (DW),
      .DEPTH  (DP),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req    (clr_req),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_index   (wr_index),
      .wr_data    (wr_data),
      .rd_index   (rd_index),
      .rd_data    (rd_data),
      .past1_data (past1_data),
      .past2_data (past2_data),
      .past_valid (past_valid),
      .busy       (busy),
      .wr_count   (wr_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [DW-1:0] m_regs [DP];
   logic          m_clear;
   int            m_ptr;
   logic [CW-1:0] m_cnt;
   logic [DW-1:0] hq [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rdy"}, wr_ready, 0);
      chk({tag, "_p1"}, past1_data, 0);
      chk({tag, "_p2"}, past2_data, 0);
      chk({tag, "_pv"}, past_valid, 0);
      chk({tag, "_cnt"}, wr_count, 0);
   endtask

   task automatic model_reset();
      m_clear = 1'b1;
      m_ptr   = 0;
      m_cnt   = '0;
      hq.delete();
   endtask

   // One clock: check pre-edge outputs, advance model at the edge.
   task automatic cyc();
      logic [DW-1:0] e;
      logic [DW-1:0] p1;
      logic [DW-1:0] p2;
      logic          acc;
      #1;
      e  = m_regs[rd_index];
      p1 = (hq.size() > 0) ? hq[hq.size()-1] : '0;
      p2 = (hq.size() > 1) ? hq[0] : '0;
      chk("busy", busy, m_clear);
      chk("wr_ready", wr_ready, rst_n && !m_clear && !clr_req);
      chk("wr_count", wr_count, m_cnt);
      chk("past_valid", past_valid,
          (hq.size() == 0) ? 0 : (hq.size() == 1) ? 1 : 3);
      if (!$isunknown(e))  chk("rd_data", rd_data, e);
      if (!$isunknown(p1)) chk("past1", past1_data, p1);
      if (!$isunknown(p2)) chk("past2", past2_data, p2);
      @(posedge clk);
      if (rst_n) begin
         hq.push_back(e);
         if (hq.size() > 2) void'(hq.pop_front());
         acc = wr_valid && !m_clear && !clr_req;
         if (m_clear) begin
            m_regs[m_ptr] = '0;
            if (m_ptr == DP - 1) begin
               m_clear = 1'b0;
               m_ptr   = 0;
            end else begin
               m_ptr++;
            end
         end else if (clr_req) begin
            m_clear = 1'b1;
            m_ptr   = 0;
         end
         if (acc) begin
            m_regs[wr_index] = wr_data;
            m_cnt++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      clr_req  = 1'b0;
      wr_valid = 1'b1;
      wr_index = '0;
      wr_data  = '0;
      rd_index = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      rst_chk("rst0");

      // 1: sweep after reset, write held off for exactly 8 cycles
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("clr_busy", busy, 1);
         chk("clr_rdy", wr_ready, 0);
         cyc();
      end
      chk("idle_busy", busy, 0);
      chk("idle_rdy", wr_ready, 1);
      cyc();
      wr_valid = 1'b0;
      chk("cnt_first", wr_count, 1);
      for (int i = 0; i < 8; i++) begin
         rd_index = IW'(i);
         #1;
         chk("rd_init", rd_data, 0);
         cyc();
      end

      // 2: back-to-back writes with history
      rd_index = 3'd3;
      wr_valid = 1'b1;
      wr_index = 3'd3;
      wr_data  = 8'hA5;
      #1 chk("t2_rd0", rd_data, 8'h00);
      cyc();
      wr_data = 8'h5A;
      #1 chk("t2_rd1", rd_data, 8'hA5);
      cyc();
      wr_valid = 1'b0;
      #1;
      chk("t2_rd2", rd_data, 8'h5A);
      chk("t2_p1a", past1_data, 8'hA5);
      chk("t2_p2a", past2_data, 8'h00);
      cyc();
      #1;
      chk("t2_p1b", past1_data, 8'h5A);
      chk("t2_p2b", past2_data, 8'hA5);
      chk("t2_cnt", wr_count, 3);

      // 3: same-cycle read/write shows old data
      rd_index = 3'd5;
      wr_valid = 1'b1;
      wr_index = 3'd5;
      wr_data  = 8'h77;
      #1 chk("t3_old", rd_data, 8'h00);
      cyc();
      wr_valid = 1'b0;
      #1 chk("t3_new", rd_data, 8'h77);
      cyc();

      // 4: clr_req refuses the write and restarts the sweep
      clr_req  = 1'b1;
      wr_valid = 1'b1;
      wr_index = 3'd1;
      wr_data  = 8'hFF;
      rd_index = 3'd1;
      #1 chk("t4_rdy", wr_ready, 0);
      cyc();
      clr_req  = 1'b0;
      wr_index = 3'd6;
      wr_data  = 8'h00;
      chk("t4_cnt", wr_count, 4);
      for (int i = 0; i < 8; i++) begin
         chk("t4_busy", busy, 1);
         cyc();
      end
      chk("t4_idle", busy, 0);
      cyc();
      wr_valid = 1'b0;
      #1;
      chk("t4_rd1", rd_data, 8'h00);
      chk("t4_cnt2", wr_count, 5);

      // 5: 16 writes wrap the counter
      wr_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_index = IW'(i % 8);
         wr_data  = DW'(i * 17);
         cyc();
         if (i == 9)  chk("t5_max", wr_count, 15);
         if (i == 10) chk("t5_wrap", wr_count, 0);
      end
      wr_valid = 1'b0;
      rd_index = 3'd7;
      #1;
      chk("t5_cnt", wr_count, 5);
      chk("t5_rd7", rd_data, 8'hFF);
      cyc();

      // 6: reset in the middle of a sweep
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      repeat (4) cyc();
      rst_n = 1'b0;
      #1;
      model_reset();
      rst_chk("t6_rst");
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t6_busy", busy, 1);
         cyc();
      end
      chk("t6_idle", busy, 0);
      #1 chk("t6_rd7", rd_data, 8'h00);
      cyc();
      rd_index = 3'd4;
      cyc();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
